silife_sequencer: RTL and testbench
===================================

Name: silife_sequencer

Overview:
Controller in front of the silife cell matrix. It generates the one-cycle matrix `enable` (generation tick) from a programmable prescaler or a single-step request. It also turns a valid/ready cell-write port (x, y, value, clear-all) into one-hot `set_cells` / `clear_cells` pulses. It guarantees a write pulse and a generation tick never drive the matrix in the same cycle, and it counts generations.

Parameters:
WIDTH, 8, matrix columns
HEIGHT, 8, matrix rows
XW, 3, width of wr_x (≥ clog2(WIDTH))
YW, 3, width of wr_y (≥ clog2(HEIGHT))
PRESCALE_W, 16, width of period and prescaler counter
GEN_W, 16, width of generation counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous reset, active-high
run  input  1  level; 1 = free-running evolution
step  input  1  single-cycle pulse; one generation when run=0
period  input  PRESCALE_W  tick interval minus one (0 = tick every cycle)
wr_valid  input  1  cell-write request
wr_ready  output  1  write accepted when wr_valid & wr_ready
wr_x  input  XW  column
wr_y  input  YW  row
wr_value  input  1  1 = set cell, 0 = clear cell
wr_clear_all  input  1  with write: clear entire matrix (x/y/value ignored)
wr_error  output  1  one-cycle pulse: accepted write was out of range
enable  output  1  to matrix enable; one-cycle generation pulse
set_cells  output  WIDTH*HEIGHT  to matrix set_cells
clear_cells  output  WIDTH*HEIGHT  to matrix clear_cells
generation  output  GEN_W  generations executed, wraps modulo 2^GEN_W

Behaviour:
- Reset (async, any time, mid-operation included): enable=0, set_cells=0, clear_cells=0, wr_error=0, generation=0, prescaler=0, tick_pending=0. wr_ready=1 immediately after reset because it is combinational !tick_pending.
- All outputs except wr_ready are registered.
- Prescaler:
  - While run=1, the counter increments each cycle.
  - When counter ≥ period, the counter goes to 0 and tick_pending is set at that edge.
  - Comparison is ≥, so lowering period mid-count fires on the next cycle.
  - When run=0, the counter is held at 0.
- Step: a step pulse with run=0 sets tick_pending at the next edge. Step with run=1 is ignored. Step while tick_pending=1 is absorbed; there is no queue of more than one.
- Tick issue:
  - With tick_pending=1, the next edge drives enable=1 for exactly one cycle, clears tick_pending and increments generation.
  - Latency is step pulse at cycle N → tick_pending N+1 → enable N+2.
  - With period=P and run=1, enable pulses every P+1 cycles.
  - If tick_pending and a new prescaler terminal count coincide, one tick is issued and no double count occurs. This cannot occur for P≥1. For P=0, enable is high every other cycle.
- Write arbitration:
  - wr_ready = !tick_pending, so writes stall for at most one cycle per tick.
  - An accepted write at cycle N produces a one-cycle pulse at N+1. A tick can only be pending from N+1 onward, so its enable lands at N+2 or later. set/clear pulses and enable are therefore never simultaneous.
- Write decode, at index = wr_y*WIDTH + wr_x:
  - wr_clear_all=1: clear_cells = all ones for one cycle, set_cells = 0. generation is reset to 0 at that same edge; a simultaneous tick increment is overridden.
  - wr_value=1: only bit index of set_cells is 1.
  - wr_value=0: only bit index of clear_cells is 1.
  - wr_x ≥ WIDTH or wr_y ≥ HEIGHT (with clear_all=0): the write is accepted, no cell pulse is issued, and wr_error pulses for one cycle at N+1.
- Back-to-back accepted writes produce back-to-back one-cycle pulses. Each pulse lasts exactly one cycle.
- Run deasserted mid-count: counter returns to 0. An already-set tick_pending is still issued.
- generation wraps from 2^GEN_W−1 to 0.

Test Plan:
- Reset, then run=1, period=3 → enable pulses every 4 cycles, one cycle wide; generation reads 1, 2, 3 after the 1st, 2nd and 3rd pulses.
- run=0, step pulse at cycle 10 → enable high only at cycle 12, generation +1. A second step at cycle 11 does not produce an extra tick.
- Write x=2, y=5, value=1 accepted at cycle N → set_cells == 1<<42 at N+1 only, clear_cells=0. Same with value=0 → clear_cells == 1<<42.
- Write with x=9 (WIDTH=8) → no set/clear bits, wr_error pulses once at N+1.
- run=1, period=0 with wr_valid held high continuously:
  - wr_ready alternates with tick_pending;
  - set_cells and enable are never both nonzero in any cycle;
  - every accepted write is reflected exactly once.
- clear_all after 5 generations → clear_cells all ones for one cycle, generation=0. Then assert reset asynchronously mid-count → all outputs 0 immediately, counting restarts.

Source files
------------

// File: rtl/silife_sequencer.sv
// Sequencer for the silife cell matrix: it makes generation ticks from a prescaler or a
// single-step request, and it turns cell writes into one-hot set/clear pulses.
module silife_sequencer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned HEIGHT     = 8,
  parameter int unsigned XW         = 3,
  parameter int unsigned YW         = 3,
  parameter int unsigned PRESCALE_W = 16,
  parameter int unsigned GEN_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     step,
  input  logic [PRESCALE_W-1:0]    period,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [XW-1:0]            wr_x,
  input  logic [YW-1:0]            wr_y,
  input  logic                     wr_value,
  input  logic                     wr_clear_all,
  output logic                     wr_error,
  output logic                     enable,
  output logic [WIDTH*HEIGHT-1:0]  set_cells,
  output logic [WIDTH*HEIGHT-1:0]  clear_cells,
  output logic [GEN_W-1:0]         generation
);

  localparam int unsigned NCELLS = WIDTH * HEIGHT;
  localparam int unsigned IW     = (NCELLS > 1) ? $clog2(NCELLS) : 1;

  typedef enum logic {
    TICK_IDLE    = 1'b0,
    TICK_PENDING = 1'b1
  } tick_state_t;

  tick_state_t             state;
  tick_state_t             state_next;
  logic [PRESCALE_W-1:0]   prescaler;
  logic [PRESCALE_W-1:0]   prescaler_next;
  logic                    terminal_c;
  logic                    issue_c;
  logic                    accept_c;
  logic                    in_range_c;
  logic [IW-1:0]           index_c;
  logic [NCELLS-1:0]       cell_onehot_c;

  // Prescaler: >= so that lowering period mid-count fires on the next cycle
  always_comb begin
    terminal_c     = 1'b0;
    prescaler_next = '0;
    if (run) begin
      if (prescaler >= period) begin
        terminal_c = 1'b1;
      end else begin
        prescaler_next = prescaler + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler_next;
    end
  end

  // Tick state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= TICK_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A pending tick absorbs any coincident terminal count or step
  always_comb begin
    state_next = state;
    case (state)
      TICK_IDLE: begin
        if (terminal_c || (step && !run)) begin
          state_next = TICK_PENDING;
        end
      end
      TICK_PENDING: state_next = TICK_IDLE;
      default:      state_next = TICK_IDLE;
    endcase
  end

  // Writes are held off while a tick is pending so pulses never overlap enable
  always_comb begin
    issue_c  = 1'b0;
    wr_ready = 1'b1;
    if (state == TICK_PENDING) begin
      issue_c  = 1'b1;
      wr_ready = 1'b0;
    end
  end

  // Write address decode
  always_comb begin
    accept_c      = wr_valid && wr_ready;
    in_range_c    = (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);
    index_c       = IW'(32'(wr_y) * WIDTH + 32'(wr_x));
    cell_onehot_c = NCELLS'(1) << index_c;
  end

  // Registered matrix-side outputs; every pulse lasts exactly one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable      <= 1'b0;
      set_cells   <= '0;
      clear_cells <= '0;
      wr_error    <= 1'b0;
    end else begin
      enable      <= issue_c;
      set_cells   <= '0;
      clear_cells <= '0;
      wr_error    <= 1'b0;
      if (accept_c) begin
        if (wr_clear_all) begin
          clear_cells <= '1;
        end else if (!in_range_c) begin
          wr_error <= 1'b1;
        end else if (wr_value) begin
          set_cells <= cell_onehot_c;
        end else begin
          clear_cells <= cell_onehot_c;
        end
      end
    end
  end

  // Generation counter; clear-all wins over a same-edge tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      generation <= '0;
    end else if (accept_c && wr_clear_all) begin
      generation <= '0;
    end else if (issue_c) begin
      generation <= generation + GEN_W'(1);
    end
  end

endmodule

// File: tb/tb_silife_sequencer.sv
// Scoreboard bench for silife_sequencer: directed scenarios then random traffic,
// compared cycle by cycle against a rule-level reference model.
module tb_silife_sequencer;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned HEIGHT = 8;
  localparam int unsigned XW     = 4;
  localparam int unsigned YW     = 4;
  localparam int unsigned PW     = 8;
  localparam int unsigned GW     = 5;
  localparam int unsigned NC     = WIDTH * HEIGHT;
  localparam int          GMOD   = 1 << GW;

  logic             clk;
  logic             reset;
  logic             run;
  logic             step;
  logic [PW-1:0]    period;
  logic             wr_valid;
  logic             wr_ready;
  logic [XW-1:0]    wr_x;
  logic [YW-1:0]    wr_y;
  logic             wr_value;
  logic             wr_clear_all;
  logic             wr_error;
  logic             enable;
  logic [NC-1:0]    set_cells;
  logic [NC-1:0]    clear_cells;
  logic [GW-1:0]    generation;

  silife_sequencer #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW), .PRESCALE_W(PW), .GEN_W(GW)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .period(period),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_value(wr_value), .wr_clear_all(wr_clear_all), .wr_error(wr_error),
    .enable(enable), .set_cells(set_cells), .clear_cells(clear_cells),
    .generation(generation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic [NC-1:0] set_v;
    logic [NC-1:0] clr_v;
    logic          err;
    logic [GW-1:0] gen;
    logic          rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  // Reference model state: cycles counted since last tick, whether a tick is owed, generations
  int m_cnt  = 0;
  bit m_owed = 0;
  int m_gen  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Apply the current inputs for one clock: predict the post-edge outputs, queue them, advance
  task automatic cycle();
    exp_t          e;
    bit            tick_now;
    bit            accepted;
    bit            wrapped;
    int            idx;
    logic [NC-1:0] one;
    e.en = 0; e.set_v = '0; e.clr_v = '0; e.err = 0; e.gen = '0; e.rdy = 1;
    if (reset) begin
      m_cnt = 0; m_owed = 0; m_gen = 0;
    end else begin
      tick_now = m_owed;
      accepted = wr_valid && !m_owed;
      wrapped  = run && (m_cnt >= int'(period));
      e.en = tick_now;
      if (accepted) begin
        if (wr_clear_all) e.clr_v = '1;
        else if (int'(wr_x) >= int'(WIDTH) || int'(wr_y) >= int'(HEIGHT)) e.err = 1;
        else begin
          idx = int'(wr_y) * int'(WIDTH) + int'(wr_x);
          one = 1;
          one = one << idx;
          if (wr_value) e.set_v = one; else e.clr_v = one;
        end
      end
      if (accepted && wr_clear_all) m_gen = 0;
      else if (tick_now) m_gen = (m_gen + 1) % GMOD;
      m_cnt  = (!run || wrapped) ? 0 : m_cnt + 1;
      m_owed = tick_now ? 1'b0 : (wrapped || (step && !run));
      e.gen = GW'(m_gen);
      e.rdy = !m_owed;
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic write_cell(input int x, input int y, input bit v, input bit c);
    wr_valid = 1; wr_x = XW'(x); wr_y = YW'(y); wr_value = v; wr_clear_all = c;
    cycle();
    wr_valid = 0; wr_clear_all = 0;
    cycle();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic async_reset();
    reset = 1;
    #1;
    check("rst_enable", 64'(enable), 64'(0));
    check("rst_set", 64'(set_cells), 64'(0));
    check("rst_clear", 64'(clear_cells), 64'(0));
    check("rst_error", 64'(wr_error), 64'(0));
    check("rst_gen", 64'(generation), 64'(0));
    check("rst_ready", 64'(wr_ready), 64'(1));
    cycle();
    reset = 0;
  endtask

  // Monitor: every clock the DUT presents a full output set; pop and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!done) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("enable", 64'(enable), 64'(e.en));
          check("set_cells", 64'(set_cells), 64'(e.set_v));
          check("clear_cells", 64'(clear_cells), 64'(e.clr_v));
          check("wr_error", 64'(wr_error), 64'(e.err));
          check("generation", 64'(generation), 64'(e.gen));
          check("wr_ready", 64'(wr_ready), 64'(e.rdy));
          check("write_tick_overlap",
                64'(enable && ((set_cells | clear_cells) != '0)), 64'(0));
        end
      end
    end
  end

  initial begin
    reset = 1; run = 0; step = 0; period = PW'(3);
    wr_valid = 0; wr_x = '0; wr_y = '0; wr_value = 0; wr_clear_all = 0;
    repeat (2) cycle();
    reset = 0;

    run = 1; period = PW'(3);
    repeat (14) cycle();
    run = 0;
    repeat (3) cycle();

    step = 1; cycle();
    step = 1; cycle();
    step = 0; repeat (4) cycle();

    write_cell(2, 5, 1, 0);
    write_cell(2, 5, 0, 0);
    write_cell(9, 1, 1, 0);
    write_cell(1, 9, 0, 0);

    run = 1; period = PW'(0); wr_valid = 1;
    for (int i = 0; i < 24; i++) begin
      wr_x = XW'($urandom_range(0, 9));
      wr_y = YW'($urandom_range(0, 9));
      wr_value = 1'($urandom_range(0, 1));
      cycle();
    end
    wr_valid = 0;
    repeat (70) cycle();

    period = PW'(2);
    repeat (17) cycle();
    run = 0;
    repeat (3) cycle();
    write_cell(0, 0, 0, 1);

    run = 1; period = PW'(4);
    repeat (3) cycle();
    async_reset();
    repeat (12) cycle();

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      if ($urandom_range(0, 49) == 0) period = PW'($urandom_range(0, 6));
      step         = ($urandom_range(0, 9) == 0);
      wr_valid     = ($urandom_range(0, 9) < 4);
      wr_x         = XW'($urandom_range(0, 9));
      wr_y         = YW'($urandom_range(0, 9));
      wr_value     = 1'($urandom_range(0, 1));
      wr_clear_all = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) async_reset();
      else cycle();
    end

    done = 1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
